add_result_collector: RTL and testbench
=======================================

Name: add_result_collector

Overview:
Downstream stage of add_module in the VFU.
- Per-lane FP16 results arrive with independent out_tvalid bits, and add_module has no output back-pressure.
- This block latches each lane's result, and assembles a complete N-lane vector once every lane has delivered.
- It buffers vectors in a small FIFO and presents them to the next VFU stage over a single valid/ready handshake.
- Per-lane in_tready is used by the issue logic to gate add_module's in_tvalid; an overflow flag catches protocol violations.

Parameters:
N, 4, number of FP16 lanes (must match add_module N)
DEPTH, 2, output FIFO depth in vectors (power of two, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_tvalid  input  N  per-lane result valid, driven by add_module out_tvalid
in_data_flat  input  N*16  per-lane FP16 results, driven by add_module add_out_flat, lane i at [i*16 +:16]
in_tready  output  N  lane i may accept a result this cycle; the issue logic gates add_module in_tvalid with it
out_tvalid  output  1  assembled vector available
out_tready  input  1  downstream accepts the vector
out_data_flat  output  N*16  assembled vector, lane i at [i*16 +:16]
fifo_count  output  $clog2(DEPTH)+1  vectors held in the FIFO
overflow  output  1  sticky: a lane result arrived while its slot was full and not draining
ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, async) clears:
  - lane_full[N], lane_data, FIFO pointers, count and overflow.
  - Outputs: out_tvalid=0, out_data_flat=0, fifo_count=0, overflow=0, in_tready={N{1}}.
- Lane capture:
  - Lane i captures in_data on an edge where in_tvalid[i]=1 and (lane_full[i]=0 or drain=1); lane_full[i] is then set.
  - Data is taken bit-exact, with no FP16 manipulation.
- drain is combinational: (&lane_full) && (fifo_count<DEPTH || pop). On a drain edge the vector is pushed into the FIFO and every lane_full is cleared.
- Same-edge drain + capture on lane i: the capture wins. lane_full[i] stays 1 with the new data, and the old data goes to the FIFO.
- in_tready[i] = !lane_full[i] || drain, combinational.
- Overflow:
  - in_tvalid[i]=1 while in_tready[i]=0 drops the result, sets overflow and leaves the slot unchanged.
  - ovf_clr=1 clears overflow; if a new violation occurs in the same cycle, set wins.
- FIFO:
  - pop = out_tvalid && out_tready; out_tvalid = (fifo_count!=0).
  - out_data_flat is the head entry, registered and held stable while out_tvalid && !out_tready.
  - When empty, out_data_flat holds its last value.
  - Push and pop on the same edge: fifo_count unchanged, and this is legal when full.
  - Pointers wrap modulo DEPTH.
- Latency:
  - The last lane is sampled at edge E and the vector is pushed at edge E+1.
  - out_tvalid=1 after edge E+1, with no bypass path.
  - Throughput: one vector per cycle sustained when lanes all arrive every cycle and out_tready=1.
- Lanes may complete in any order and on different cycles. Partial vectors wait indefinitely; there is no timeout.
- Reset mid-operation discards partial lanes and FIFO contents immediately. Upstream in-flight results after reset are accepted as new data.

Decomposition:
- Shared VFU package:
  - FP16_W=16 constant.
  - fp16_t typedef.
  - LANE_SLICE helper constant/function for [i*16 +:16] indexing.
- One sub-module, vfu_vec_fifo (parameterised WIDTH=N*16, DEPTH), which provides push/pop/count/full/empty.
- Lane registers, drain logic and overflow stay in the top.

Test Plan:
1. Reset, then all 4 lanes valid on one cycle with 3E00,4100,4300,4480 and out_tready=1 -> out_tvalid=1 two edges later, out_data_flat=4480_4300_4100_3E00, then out_tvalid=0; overflow=0.
2. Lanes arrive staggered in order 2,0,3,1 on separate cycles -> no out_tvalid until 1 cycle after lane 1. in_tready[2] goes 0 after its capture, then returns to 1 after the drain.
3. out_tready=0, 3 full vectors issued back-to-back -> fifo_count reaches 2; the third vector stays in the lanes and in_tready=0. Raise out_tready -> vectors pop in order, with no loss or duplication.
4. Lane 0 is full and not draining, and in_tvalid[0] is pulsed with 5000 -> overflow=1, the slot keeps its old value. Then ovf_clr=1 -> overflow=0 on the next edge.
5. Drain and new capture on the same edge for all lanes (continuous valid, out_tready=1) -> one vector per cycle, fifo_count stays at or below 1, no overflow.
6. Assert rst=0 asynchronously with 2 lanes captured and 1 vector in the FIFO -> out_tvalid, fifo_count and overflow drop immediately, in_tready={N{1}}, and no stale vector appears after reset release.

Source files
------------

// File: rtl/add_result_collector_pkg.sv
// Shared VFU definitions: FP16 lane type and lane slicing helper for flat
// N-lane vectors (lane i lives at [i*FP16_W +: FP16_W]).
package add_result_collector_pkg;

    localparam int FP16_W = 16;

    typedef logic [FP16_W-1:0] fp16_t;

    // Base bit index of lane i inside a flat lane vector.
    function automatic int lane_base(input int lane_idx);
        return lane_idx * FP16_W;
    endfunction

endpackage : add_result_collector_pkg

// File: rtl/add_result_collector_vec_fifo.sv
// Small vector FIFO with a registered head output. The head register is
// loaded with whatever entry will sit at the read pointer after the edge,
// so the output is stable while not popped and holds its last value when
// the FIFO runs empty. Push is accepted when full only together with pop.
module vfu_vec_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Next-state for storage, pointers, occupancy and the registered head.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        pop_ok_s  = pop && (count_q != {CNT_W{1'b0}});
        push_ok_s = push && ((count_q != DEPTH_C) || pop_ok_s);

        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // mem_d already carries this edge's write, so a vector pushed into
        // an empty FIFO lands in the head register directly.
        if (count_d != {CNT_W{1'b0}}) begin
            head_d = mem_d[rd_ptr_d];
        end else begin
            head_d = head_q;
        end
    end

    // State registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            head_q   <= {WIDTH{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign data_out = head_q;
    assign count    = count_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == {CNT_W{1'b0}});

endmodule : vfu_vec_fifo

// File: rtl/add_result_collector.sv
// Collects per-lane FP16 results from add_module, assembles a full N-lane
// vector once every lane has delivered, and queues vectors for the next VFU
// stage. add_module cannot be stalled, so in_tready is advisory for the
// issue logic and any result arriving at a busy lane is dropped and flagged.
module add_result_collector
    import add_result_collector_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            in_tvalid,
    input  logic [N*16-1:0]         in_data_flat,
    output logic [N-1:0]            in_tready,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [N*16-1:0]         out_data_flat,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    input  logic                    ovf_clr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int VEC_W = N * FP16_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [N-1:0]     lane_full_q, lane_full_d;
    fp16_t            lane_data_q [N];
    fp16_t            lane_data_d [N];
    logic             overflow_q, overflow_d;

    logic [N-1:0]     in_tready_s;
    logic [N-1:0]     cap_s;
    logic [N-1:0]     viol_s;
    logic             pop_s;
    logic             drain_s;
    logic [VEC_W-1:0] push_vec_s;

    logic [VEC_W-1:0] fifo_data_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    // Drain/ready/capture decisions and next lane and overflow state.
    always_comb begin
        lane_full_d = lane_full_q;
        lane_data_d = lane_data_q;
        overflow_d  = overflow_q;
        in_tready_s = {N{1'b0}};
        cap_s       = {N{1'b0}};
        viol_s      = {N{1'b0}};
        push_vec_s  = {VEC_W{1'b0}};

        pop_s   = !fifo_empty_s && out_tready;
        drain_s = (&lane_full_q) && ((fifo_count_s < DEPTH_C) || pop_s);

        for (int i = 0; i < N; i++) begin
            in_tready_s[i] = !lane_full_q[i] || drain_s;
            cap_s[i]       = in_tvalid[i] && in_tready_s[i];
            viol_s[i]      = in_tvalid[i] && !in_tready_s[i];
            push_vec_s[lane_base(i) +: FP16_W] = lane_data_q[i];

            // A capture on the drain edge keeps the lane full with new data;
            // the old contents leave through push_vec_s.
            if (cap_s[i]) begin
                lane_full_d[i] = 1'b1;
                lane_data_d[i] = in_data_flat[lane_base(i) +: FP16_W];
            end else if (drain_s) begin
                lane_full_d[i] = 1'b0;
            end else begin
                lane_full_d[i] = lane_full_q[i];
            end
        end

        // A fresh violation beats a clear in the same cycle.
        if (|viol_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Lane slots and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_full_q <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                lane_data_q[i] <= {FP16_W{1'b0}};
            end
            overflow_q <= 1'b0;
        end else begin
            lane_full_q <= lane_full_d;
            lane_data_q <= lane_data_d;
            overflow_q  <= overflow_d;
        end
    end

    vfu_vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (drain_s),
        .push_data (push_vec_s),
        .pop       (pop_s),
        .data_out  (fifo_data_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign in_tready     = in_tready_s;
    assign out_tvalid    = !fifo_empty_s;
    assign out_data_flat = fifo_data_s;
    assign fifo_count    = fifo_count_s;
    assign overflow      = overflow_q;

    // Full flag is implied by fifo_count in the drain term; kept for lint.
    logic unused_s;
    assign unused_s = fifo_full_s;

endmodule : add_result_collector

// File: tb/tb_add_result_collector.sv
// Directed bench for add_result_collector (N=4, DEPTH=2).
module tb_add_result_collector;

    logic        clk;
    logic        rst;
    logic [3:0]  in_tvalid;
    logic [63:0] in_data_flat;
    logic [3:0]  in_tready;
    logic        out_tvalid;
    logic        out_tready;
    logic [63:0] out_data_flat;
    logic [1:0]  fifo_count;
    logic        overflow;
    logic        ovf_clr;

    int n_checks = 0;
    int n_pass   = 0;

    add_result_collector #(.N(4), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_tvalid     (in_tvalid),
        .in_data_flat  (in_data_flat),
        .in_tready     (in_tready),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .out_data_flat (out_data_flat),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] vec(input int k);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i*16 +: 16] = 16'hC000 + 16'(k * 16 + i);
        end
        return v;
    endfunction

    initial begin
        rst          = 1'b0;
        in_tvalid    = 4'b0000;
        in_data_flat = 64'h0;
        out_tready   = 1'b0;
        ovf_clr      = 1'b0;
        #12;
        check_eq("rst_tvalid", {63'h0, out_tvalid}, 64'h0);
        check_eq("rst_data", out_data_flat, 64'h0);
        check_eq("rst_count", {62'h0, fifo_count}, 64'h0);
        check_eq("rst_ovf", {63'h0, overflow}, 64'h0);
        check_eq("rst_tready", {60'h0, in_tready}, 64'hF);
        rst = 1'b1;
        step();

        // 1: all lanes at once
        out_tready   = 1'b1;
        in_tvalid    = 4'b1111;
        in_data_flat = 64'h4480_4300_4100_3E00;
        step();
        in_tvalid = 4'b0000;
        check_eq("t1_no_bypass", {63'h0, out_tvalid}, 64'h0);
        check_eq("t1_tready_drain", {60'h0, in_tready}, 64'hF);
        step();
        check_eq("t1_tvalid", {63'h0, out_tvalid}, 64'h1);
        check_eq("t1_data", out_data_flat, 64'h4480_4300_4100_3E00);
        check_eq("t1_count", {62'h0, fifo_count}, 64'h1);
        step();
        check_eq("t1_popped", {63'h0, out_tvalid}, 64'h0);
        check_eq("t1_hold", out_data_flat, 64'h4480_4300_4100_3E00);
        check_eq("t1_ovf", {63'h0, overflow}, 64'h0);

        // 2: staggered lanes 2,0,3,1
        in_data_flat = 64'hA003_A002_A001_A000;
        in_tvalid = 4'b0100; step();
        check_eq("t2_rdy_a", {60'h0, in_tready}, 64'hB);
        in_tvalid = 4'b0001; step();
        check_eq("t2_rdy_b", {60'h0, in_tready}, 64'hA);
        in_tvalid = 4'b1000; step();
        check_eq("t2_rdy_c", {60'h0, in_tready}, 64'h2);
        check_eq("t2_wait", {63'h0, out_tvalid}, 64'h0);
        in_tvalid = 4'b0010; step();
        in_tvalid = 4'b0000;
        check_eq("t2_wait2", {63'h0, out_tvalid}, 64'h0);
        check_eq("t2_rdy_drain", {60'h0, in_tready}, 64'hF);
        step();
        check_eq("t2_tvalid", {63'h0, out_tvalid}, 64'h1);
        check_eq("t2_data", out_data_flat, 64'hA003_A002_A001_A000);
        check_eq("t2_rdy_after", {60'h0, in_tready}, 64'hF);
        step();
        check_eq("t2_popped", {63'h0, out_tvalid}, 64'h0);

        // 3: back-pressure, 3 vectors
        out_tready = 1'b0;
        in_tvalid  = 4'b1111;
        in_data_flat = vec(1); step();
        in_data_flat = vec(2); step();
        in_data_flat = vec(3); step();
        in_tvalid = 4'b0000;
        check_eq("t3_count", {62'h0, fifo_count}, 64'h2);
        check_eq("t3_rdy_full", {60'h0, in_tready}, 64'h0);
        check_eq("t3_head", out_data_flat, vec(1));
        step();
        check_eq("t3_stable", out_data_flat, vec(1));
        check_eq("t3_count_hold", {62'h0, fifo_count}, 64'h2);
        out_tready = 1'b1;
        #1;
        check_eq("t3_rdy_pop", {60'h0, in_tready}, 64'hF);
        step();
        check_eq("t3_v2", out_data_flat, vec(2));
        check_eq("t3_count_pp", {62'h0, fifo_count}, 64'h2);
        step();
        check_eq("t3_v3", out_data_flat, vec(3));
        check_eq("t3_count_1", {62'h0, fifo_count}, 64'h1);
        step();
        check_eq("t3_empty", {63'h0, out_tvalid}, 64'h0);

        // 4: overflow on lane 0
        in_tvalid = 4'b0001; in_data_flat = 64'h0000_0000_0000_1234; step();
        in_data_flat = 64'h0000_0000_0000_5000; step();
        in_tvalid = 4'b0000;
        check_eq("t4_ovf_set", {63'h0, overflow}, 64'h1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check_eq("t4_ovf_clr", {63'h0, overflow}, 64'h0);
        in_tvalid = 4'b0001; ovf_clr = 1'b1; step();
        in_tvalid = 4'b0000; ovf_clr = 1'b0;
        check_eq("t4_set_wins", {63'h0, overflow}, 64'h1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check_eq("t4_ovf_clr2", {63'h0, overflow}, 64'h0);
        in_tvalid = 4'b1110; in_data_flat = 64'hB003_B002_B001_7777; step();
        in_tvalid = 4'b0000; step();
        check_eq("t4_slot_kept", out_data_flat, 64'hB003_B002_B001_1234);
        step();

        // 5: continuous stream
        in_tvalid = 4'b1111;
        for (int k = 1; k <= 6; k++) begin
            in_data_flat = vec(k);
            step();
            if (k >= 2) begin
                check_eq("t5_head", out_data_flat, vec(k - 1));
                check_eq("t5_count", {62'h0, fifo_count}, 64'h1);
            end
        end
        in_tvalid = 4'b0000;
        step();
        check_eq("t5_last", out_data_flat, vec(6));
        step();
        check_eq("t5_empty", {63'h0, out_tvalid}, 64'h0);
        check_eq("t5_ovf", {63'h0, overflow}, 64'h0);

        // 6: async reset mid-operation
        out_tready = 1'b0;
        in_tvalid = 4'b1111; in_data_flat = vec(7); step();
        in_tvalid = 4'b0000; step();
        in_tvalid = 4'b0011; in_data_flat = vec(8); step();
        in_tvalid = 4'b0001; step();
        in_tvalid = 4'b0000;
        check_eq("t6_pre_cnt", {62'h0, fifo_count}, 64'h1);
        check_eq("t6_pre_ovf", {63'h0, overflow}, 64'h1);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_tvalid", {63'h0, out_tvalid}, 64'h0);
        check_eq("t6_count", {62'h0, fifo_count}, 64'h0);
        check_eq("t6_ovf", {63'h0, overflow}, 64'h0);
        check_eq("t6_tready", {60'h0, in_tready}, 64'hF);
        #3 rst = 1'b1;
        out_tready = 1'b1;
        step(); step();
        check_eq("t6_no_stale", {63'h0, out_tvalid}, 64'h0);
        in_tvalid = 4'b1100; in_data_flat = vec(9); step();
        in_tvalid = 4'b0000;
        check_eq("t6_partial", {60'h0, in_tready}, 64'h3);
        step();
        check_eq("t6_no_vec", {63'h0, out_tvalid}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_add_result_collector
